// File: rtl/segre_icache_controller.sv
// Instruction-cache sequencer: tag/valid lookup, MMU lane refill and
// a one-lane-per-cycle invalidation sweep for fence.i.
module segre_icache_controller #(
  parameter int WORD_SIZE = 32,
  parameter int LANE_SIZE = 128,
  parameter int NUM_LANES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fetch_req_i,
  input  logic [WORD_SIZE-1:0] fetch_addr_i,
  output logic                 fetch_rdy_o,
  output logic                 fetch_valid_o,
  output logic [WORD_SIZE-1:0] fetch_data_o,
  input  logic                 flush_i,
  output logic                 flush_busy_o,
  output logic                 arr_rd_o,
  output logic                 arr_wr_o,
  output logic [WORD_SIZE-1:0] arr_addr_o,
  input  logic [WORD_SIZE-1:0] arr_data_i,
  output logic                 mmu_req_o,
  output logic [WORD_SIZE-1:0] mmu_addr_o,
  input  logic                 mmu_ack_i
);

  localparam int BYTE_SIZE  = $clog2(LANE_SIZE / 8);
  localparam int INDEX_SIZE = $clog2(NUM_LANES);
  localparam int TAG_SIZE   = WORD_SIZE - INDEX_SIZE - BYTE_SIZE;
  localparam logic [WORD_SIZE-1:0] WMASK = ~WORD_SIZE'(3);
  localparam logic [INDEX_SIZE-1:0] LAST = INDEX_SIZE'(NUM_LANES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS,
    RESP,
    FLUSH
  } state_e;

  state_e                  state_q, state_d;
  logic [WORD_SIZE-1:0]    addr_q, addr_d;
  logic [WORD_SIZE-1:0]    data_q, data_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [INDEX_SIZE-1:0]   cnt_q, cnt_d;
  logic [NUM_LANES-1:0]    valid_q;
  logic [TAG_SIZE-1:0]     tag_q [NUM_LANES];

  logic [INDEX_SIZE-1:0]   idx;
  logic [TAG_SIZE-1:0]     atag;
  logic                    hit;
  logic                    fill_we;
  logic                    clr_we;

  assign idx  = addr_q[BYTE_SIZE +: INDEX_SIZE];
  assign atag = addr_q[WORD_SIZE-1 -: TAG_SIZE];
  assign hit  = valid_q[idx] && (tag_q[idx] == atag);
  assign flush_busy_o = flush_pend_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    flush_pend_d  = flush_pend_q | flush_i;
    cnt_d         = cnt_q;
    fetch_rdy_o   = 1'b0;
    fetch_valid_o = 1'b0;
    fetch_data_o  = data_q;
    arr_rd_o      = 1'b0;
    arr_wr_o      = 1'b0;
    arr_addr_o    = addr_q & WMASK;
    mmu_req_o     = 1'b0;
    mmu_addr_o    = '0;
    fill_we       = 1'b0;
    clr_we        = 1'b0;
    unique case (state_q)
      IDLE: begin
        arr_addr_o  = '0;
        fetch_rdy_o = !flush_pend_q && !flush_i;
        if (flush_pend_q || flush_i) begin
          state_d = FLUSH;
        end else if (fetch_req_i) begin
          addr_d  = fetch_addr_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          arr_rd_o = 1'b1;
          state_d  = RESP;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        mmu_req_o  = 1'b1;
        mmu_addr_o = {addr_q[WORD_SIZE-1:BYTE_SIZE], {BYTE_SIZE{1'b0}}};
        if (mmu_ack_i) begin
          arr_wr_o = 1'b1;
          fill_we  = 1'b1;
          state_d  = LOOKUP;
        end
      end
      RESP: begin
        fetch_valid_o = 1'b1;
        fetch_data_o  = arr_data_i;
        data_d        = arr_data_i;
        state_d       = IDLE;
      end
      FLUSH: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // a new fence.i landing on the final sweep cycle stays pending
          flush_pend_d = flush_i;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
      if (fill_we) valid_q[idx] <= 1'b1;
      if (clr_we) valid_q[cnt_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && fill_we) tag_q[idx] <= atag;
  end

endmodule

// File: tb/tb_segre_icache_controller.sv
// Bench: scoreboard of expected fetch words and hit/miss outcomes from a
// lane-map model, with a behavioural data array and MMU responder.
module tb_segre_icache_controller;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_rdy_o;
  logic        fetch_valid_o;
  logic [31:0] fetch_data_o;
  logic        flush_i;
  logic        flush_busy_o;
  logic        arr_rd_o;
  logic        arr_wr_o;
  logic [31:0] arr_addr_o;
  logic [31:0] arr_data_i;
  logic        mmu_req_o;
  logic [31:0] mmu_addr_o;
  logic        mmu_ack_i;

  always #5 clk = ~clk;

  segre_icache_controller dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .fetch_req_i  (fetch_req_i),
    .fetch_addr_i (fetch_addr_i),
    .fetch_rdy_o  (fetch_rdy_o),
    .fetch_valid_o(fetch_valid_o),
    .fetch_data_o (fetch_data_o),
    .flush_i      (flush_i),
    .flush_busy_o (flush_busy_o),
    .arr_rd_o     (arr_rd_o),
    .arr_wr_o     (arr_wr_o),
    .arr_addr_o   (arr_addr_o),
    .arr_data_i   (arr_data_i),
    .mmu_req_o    (mmu_req_o),
    .mmu_addr_o   (mmu_addr_o),
    .mmu_ack_i    (mmu_ack_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails = 0;
  bit          mvalid[16];
  logic [23:0] mtag[16];
  logic [31:0] mem[16][4];
  bit          auto_ack = 1'b0;
  int          ack_cd = 0;
  int          flush_cd = 0;
  bit          saw_mmu = 1'b0;

  function automatic logic [31:0] hashw(input logic [31:0] a);
    return ((a & 32'hFFFF_FFFC) ^ 32'h5A5A_1234) * 32'h9E37_79B1 + 32'h1357;
  endfunction

  function automatic void mclr();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // input sequencer for ack and flush pulses, driven just after the edge
  initial forever begin
    @(posedge clk);
    #1;
    mmu_ack_i = 1'b0;
    flush_i   = 1'b0;
    if (ack_cd > 0) begin
      ack_cd--;
      if (ack_cd == 0) mmu_ack_i = 1'b1;
    end
    if (flush_cd > 0) begin
      flush_cd--;
      if (flush_cd == 0) flush_i = 1'b1;
    end
  end

  // data array: lanes written from the MMU bus, read word one cycle later
  initial forever begin
    @(negedge clk);
    if (arr_wr_o)
      for (int w = 0; w < 4; w++)
        mem[arr_addr_o[7:4]][w] = hashw({mmu_addr_o[31:4], 2'(w), 2'b00});
    if (arr_rd_o) arr_data_i = mem[arr_addr_o[7:4]][arr_addr_o[3:2]];
  end

  // monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_i) begin
      saw_mmu = 1'b0;
    end else begin
      chk("rd_wr_excl", {31'b0, arr_rd_o & arr_wr_o}, 32'd0);
      if (mmu_req_o) saw_mmu = 1'b1;
      if (auto_ack && mmu_req_o && ack_cd == 0 && !mmu_ack_i)
        ack_cd = $urandom_range(1, 4);
      if (fetch_valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {31'b0, fetch_valid_o}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("fetch_data", fetch_data_o, e.data);
          chk("miss_seen", {31'b0, saw_mmu}, {31'b0, e.miss});
        end
        saw_mmu = 1'b0;
      end
    end
  end

  task automatic run_fetch(input logic [31:0] a, input int k, input int fl);
    int   n;
    bit   miss;
    logic [3:0] idx;
    @(posedge clk);
    #1;
    fetch_req_i  = 1'b1;
    fetch_addr_i = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fetch_rdy_o && n < 60);
    chk("accept", {31'b0, fetch_rdy_o}, 32'd1);
    if (!fetch_rdy_o) begin
      fetch_req_i = 1'b0;
      return;
    end
    idx  = a[7:4];
    miss = !(mvalid[idx] && mtag[idx] == a[31:8]);
    sb.push_back('{addr: a, data: hashw(a), miss: miss});
    mvalid[idx] = 1'b1;
    mtag[idx]   = a[31:8];
    @(posedge clk);
    #1;
    fetch_req_i  = 1'b0;
    fetch_addr_i = $urandom;
    @(negedge clk);
    chk("lookup_rd", {31'b0, arr_rd_o}, {31'b0, !miss});
    chk("lookup_addr", arr_addr_o, a & 32'hFFFF_FFFC);
    if (fl > 0) begin
      flush_cd = fl;
      mclr();
    end
    @(negedge clk);
    if (!miss) begin
      chk("hit_valid", {31'b0, fetch_valid_o}, 32'd1);
    end else begin
      chk("mmu_req", {31'b0, mmu_req_o}, 32'd1);
      chk("mmu_addr", mmu_addr_o, a & 32'hFFFF_FFF0);
      if (k > 0) begin
        ack_cd = k;
        repeat (k) @(negedge clk);
        chk("fill_wr", {31'b0, arr_wr_o}, 32'd1);
      end
    end
    n = 0;
    while ((sb.size() > 0 || flush_cd > 0 || flush_i) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("complete", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    int n;
    int fl;
    logic [31:0] a;
    rst_i        = 1'b1;
    fetch_req_i  = 1'b0;
    fetch_addr_i = '0;
    arr_data_i   = '0;
    mmu_ack_i    = 1'b0;
    flush_i      = 1'b0;
    mclr();
    for (int i = 0; i < 16; i++)
      for (int w = 0; w < 4; w++) mem[i][w] = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_rdy", {31'b0, fetch_rdy_o}, 32'd1);
    chk("rst_valid", {31'b0, fetch_valid_o}, 32'd0);
    chk("rst_data", fetch_data_o, 32'd0);
    chk("rst_busy", {31'b0, flush_busy_o}, 32'd0);
    chk("rst_rdwr", {30'b0, arr_rd_o, arr_wr_o}, 32'd0);
    chk("rst_arr_addr", arr_addr_o, 32'd0);
    chk("rst_mmu", {31'b0, mmu_req_o}, 32'd0);
    chk("rst_mmu_addr", mmu_addr_o, 32'd0);

    run_fetch(32'h0000_0104, 3, 0);
    run_fetch(32'h0000_0108, 0, 0);
    run_fetch(32'h0000_1104, 2, 0);
    run_fetch(32'h0000_0104, 1, 0);

    auto_ack = 1'b1;
    run_fetch(32'h0000_2208, -1, 1);
    run_fetch(32'h0000_0108, -1, 0);

    // flush and fetch together in IDLE
    @(negedge clk);
    flush_cd = 1;
    mclr();
    @(posedge clk);
    #1;
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h0000_0104;
    @(negedge clk);
    chk("prio_rdy", {31'b0, fetch_rdy_o}, 32'd0);
    @(posedge clk);
    #1 fetch_req_i = 1'b0;
    @(negedge clk);
    chk("prio_busy", {31'b0, flush_busy_o}, 32'd1);
    chk("flush_rdy", {31'b0, fetch_rdy_o}, 32'd0);
    n = 1;
    do begin
      @(negedge clk);
      if (flush_busy_o) n++;
    end while (flush_busy_o && n < 40);
    chk("flush_len", n, 32'd16);
    chk("prio_no_accept", sb.size(), 32'd0);
    run_fetch(32'h0000_0108, -1, 0);

    // reset while a refill is outstanding
    auto_ack = 1'b0;
    @(posedge clk);
    #1;
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h0000_3344;
    @(negedge clk);
    chk("rm_accept", {31'b0, fetch_rdy_o}, 32'd1);
    @(posedge clk);
    #1 fetch_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rm_req", {31'b0, mmu_req_o}, 32'd1);
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    sb.delete();
    mclr();
    @(negedge clk);
    chk("rm_req_drop", {31'b0, mmu_req_o}, 32'd0);
    ack_cd = 1;
    @(negedge clk);
    chk("late_ack_wr", {31'b0, arr_wr_o}, 32'd0);
    auto_ack = 1'b1;
    run_fetch(32'h0000_3344, -1, 0);

    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 2) << 12) | ($urandom_range(0, 15) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      fl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
      run_fetch(a, -1, fl);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
